step_driver_multi: RTL and testbench

Parametrised multi-drive stepper-coil emulator for the floppy bus. It receives the shared active-low STEP/DIR lines and, for each of NUM_DRIVES drive-select enables, debounces the step pulse and advances a one-hot 4-coil phase pattern. It also keeps a per-drive head track counter and generates TRACK0 internally instead of taking it as an input. It sits between the bus input synchronisers and the per-drive head/track logic.

---
 rtl/step_pkg.sv | 32 +++
 rtl/step_channel.sv | 112 +++++++++++
 rtl/step_driver_multi.sv | 45 ++++
 tb/tb_step_driver_multi.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared types and coil helpers for the multi-drive stepper emulator.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_CHECK = 2'd2,
    ST_WAIT  = 2'd3
  } step_state_t;

  localparam logic [3:0] COIL_RESET = 4'b0001;

  // Centre direction: 0001 > 0010 > 0100 > 1000 > 0001
  function automatic logic [3:0] coil_fwd(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  // Edge direction: 0001 > 1000 > 0100 > 0010 > 0001
  function automatic logic [3:0] coil_rev(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

  function automatic logic coil_legal(input logic [3:0] c);
    logic ok;
    case (c)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/step_channel.sv
// One drive channel: step debounce FSM, coil phase, track counter and TRACK0.
// STEP_DRIVER_LIMIT_EN: when defined, a centre step at MAX_TRACK is ignored.
module step_channel
  import step_pkg::*;
#(
  parameter int DEB_CYCLES = 25,
  parameter int CNT_W      = 8,
  parameter int TRK_W      = 7,
  parameter int MAX_TRACK  = 79
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,
  input  logic             en,
  output logic [3:0]       coils,
  output logic [TRK_W-1:0] track,
  output logic             tr0,
  output logic             step_done
);

`ifdef STEP_DRIVER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // Highest track a centre step may leave; with the limit off it is pure saturation.
  localparam logic [TRK_W-1:0] TOP_TRACK = LIMIT_EN ? TRK_W'(MAX_TRACK) : {TRK_W{1'b1}};

  step_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       coils_q, coils_d;
  logic [TRK_W-1:0] track_q, track_d;
  logic             tr0_q;
  logic             done_q;

  always_comb begin
    coils_d = coils_q;
    track_d = track_q;
    if (!dir) begin
      if (track_q != TOP_TRACK) begin
        track_d = track_q + 1'b1;
        coils_d = coil_fwd(coils_q);
      end else if (!LIMIT_EN) begin
        coils_d = coil_fwd(coils_q);
      end
    end else if (track_q != '0) begin
      track_d = track_q - 1'b1;
      coils_d = coil_rev(coils_q);
    end
    // A corrupted phase pattern is recovered on the next accepted step.
    if (!coil_legal(coils_q)) begin
      coils_d = COIL_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      coils_q <= COIL_RESET;
      track_q <= '0;
      tr0_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en && !step) begin
            state_q <= ST_COUNT;
            cnt_q   <= CNT_W'(DEB_CYCLES);
          end
        end
        ST_COUNT: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CHECK: begin
          if (!en || step) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (step) begin
            coils_q <= coils_d;
            track_q <= track_d;
            tr0_q   <= (track_d == '0);
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign coils     = coils_q;
  assign track     = track_q;
  assign tr0       = tr0_q;
  assign step_done = done_q;

endmodule

// File: rtl/step_driver_multi.sv
// Multi-drive stepper-coil emulator: one step_channel per drive select on shared STEP/DIR.
// STEP_DRIVER_LIMIT_EN: when defined, centre steps stop at MAX_TRACK.
module step_driver_multi
  import step_pkg::*;
#(
  parameter int NUM_DRIVES = 2,
  parameter int DEB_CYCLES = 25,
  parameter int CNT_W      = 8,
  parameter int TRK_W      = 7,
  parameter int MAX_TRACK  = 79
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step,
  input  logic                        dir,
  input  logic [NUM_DRIVES-1:0]       en,
  output logic [4*NUM_DRIVES-1:0]     coils,
  output logic [TRK_W*NUM_DRIVES-1:0] track,
  output logic [NUM_DRIVES-1:0]       tr0,
  output logic [NUM_DRIVES-1:0]       step_done
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DRIVES; gi++) begin : g_chan
      step_channel #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W),
        .TRK_W     (TRK_W),
        .MAX_TRACK (MAX_TRACK)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .dir      (dir),
        .en       (en[gi]),
        .coils    (coils[4*gi +: 4]),
        .track    (track[TRK_W*gi +: TRK_W]),
        .tr0      (tr0[gi]),
        .step_done(step_done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_step_driver_multi.sv
// Table-driven bench with a per-drive scoreboard checked on every step_done pulse.
module tb_step_driver_multi;

  localparam int ND   = 2;
  localparam int DEB  = 25;
  localparam int TW   = 7;
  localparam int MAXT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              step;
  logic              dir;
  logic [ND-1:0]     en;
  logic [4*ND-1:0]   coils;
  logic [TW*ND-1:0]  track;
  logic [ND-1:0]     tr0;
  logic [ND-1:0]     step_done;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  step_driver_multi #(
    .NUM_DRIVES(ND), .DEB_CYCLES(DEB), .CNT_W(8), .TRK_W(TW), .MAX_TRACK(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .en(en),
    .coils(coils), .track(track), .tr0(tr0), .step_done(step_done)
  );

  typedef struct {
    logic [1:0] en;
    logic       dir;
    int         low;
    logic [3:0] c0;
    logic [6:0] t0;
    logic [3:0] c1;
    logic [6:0] t1;
  } vec_t;

  typedef struct {
    logic [3:0] c;
    logic [6:0] t;
    logic       z;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  logic [3:0] mc[2];
  logic [6:0] mt[2];
  vec_t       tbl[14];

  function automatic vec_t mk(input logic [1:0] e, input logic d, input int l,
                              input logic [3:0] c0, input logic [6:0] t0,
                              input logic [3:0] c1, input logic [6:0] t1);
    vec_t v;
    v.en = e; v.dir = d; v.low = l; v.c0 = c0; v.t0 = t0; v.c1 = c1; v.t1 = t1;
    return v;
  endfunction

  function automatic logic [3:0] m_fwd(input logic [3:0] c);
    case (c)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0100;
      4'b0100: return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] m_rev(input logic [3:0] c);
    case (c)
      4'b0001: return 4'b1000;
      4'b1000: return 4'b0100;
      4'b0100: return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Reference behaviour of one accepted step on drive i.
  task automatic model_step(input int i, input logic d);
    exp_t e;
    if (!d) begin
`ifdef STEP_DRIVER_LIMIT_EN
      if (mt[i] != 7'(MAXT)) begin
        mc[i] = m_fwd(mc[i]);
        if (mt[i] != 7'h7f) mt[i] = mt[i] + 7'd1;
      end
`else
      mc[i] = m_fwd(mc[i]);
      if (mt[i] != 7'h7f) mt[i] = mt[i] + 7'd1;
`endif
    end else if (mt[i] != 7'd0) begin
      mc[i] = m_rev(mc[i]);
      mt[i] = mt[i] - 7'd1;
    end
    e.c = mc[i];
    e.t = mt[i];
    e.z = (mt[i] == 7'd0);
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic pulse(input logic [1:0] e, input logic d, input int low);
    en   = e;
    dir  = d;
    step = 1'b0;
    repeat (low) @(negedge clk);
    step = 1'b1;
    if (low >= DEB + 3) begin
      for (int i = 0; i < ND; i++) begin
        if (e[i]) model_step(i, d);
      end
    end
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [3:0] c0, input logic [6:0] t0,
                             input logic [3:0] c1, input logic [6:0] t1);
    logic [23:0] act, exp_v;
    act   = {coils, track, tr0};
    exp_v = {c1, c0, t1, t0, (t1 == 7'd0), (t0 == 7'd0)};
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got coils=%b track=%h tr0=%b, expected coils=%b%b track=%h%h tr0=%b%b",
               name, coils, track, tr0, c1, c0, t1, t0, (t1 == 7'd0), (t0 == 7'd0));
    end else begin
      $display("ok   %s: coils=%b track=%h tr0=%b", name, coils, track, tr0);
    end
    n_vec++;
    if (sb0.size() + sb1.size() != 0) begin
      n_fail++;
      $display("FAIL %s_done: %0d step_done pulses missing, expected 0", name, sb0.size() + sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  // Scoreboard: every step_done pulse must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < ND; i++) begin
      if (step_done[i] === 1'b1) begin
        n_vec++;
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
          n_fail++;
          $display("FAIL done%0d: unexpected step_done, coils=%b track=%h, expected no pulse", i, coils, track);
        end else begin
          e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          if ({coils[4*i +: 4], track[TW*i +: TW], tr0[i]} !== {e.c, e.t, e.z}) begin
            n_fail++;
            $display("FAIL done%0d: got coils=%b track=%0d tr0=%b, expected coils=%b track=%0d tr0=%b",
                     i, coils[4*i +: 4], track[TW*i +: TW], tr0[i], e.c, e.t, e.z);
          end else begin
            $display("ok   done%0d: coils=%b track=%0d tr0=%b", i, e.c, e.t, e.z);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; step = 1'b1; dir = 1'b0; en = '0;
    mc[0] = 4'b0001; mc[1] = 4'b0001; mt[0] = '0; mt[1] = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({coils, track, tr0, step_done} !== {8'h11, 14'h0, 2'b11, 2'b00}) begin
      n_fail++;
      $display("FAIL reset: got coils=%b track=%h tr0=%b done=%b, expected 00010001/0/11/00",
               coils, track, tr0, step_done);
    end
    rst = 1'b0;
    @(negedge clk);

    tbl[0]  = mk(2'b01, 1'b0, 40, 4'b0010, 7'd1, 4'b0001, 7'd0);
    tbl[1]  = mk(2'b01, 1'b0, 10, 4'b0010, 7'd1, 4'b0001, 7'd0);
    tbl[2]  = mk(2'b10, 1'b1, 40, 4'b0010, 7'd1, 4'b0001, 7'd0);
    tbl[3]  = mk(2'b01, 1'b1, 40, 4'b0001, 7'd0, 4'b0001, 7'd0);
    tbl[4]  = mk(2'b01, 1'b0, 40, 4'b0010, 7'd1, 4'b0001, 7'd0);
    tbl[5]  = mk(2'b01, 1'b0, 40, 4'b0100, 7'd2, 4'b0001, 7'd0);
`ifdef STEP_DRIVER_LIMIT_EN
    tbl[6]  = mk(2'b01, 1'b0, 40, 4'b0100, 7'd2, 4'b0001, 7'd0);
    tbl[7]  = mk(2'b01, 1'b0, 40, 4'b0100, 7'd2, 4'b0001, 7'd0);
    tbl[8]  = mk(2'b01, 1'b1, 40, 4'b0010, 7'd1, 4'b0001, 7'd0);
    tbl[9]  = mk(2'b10, 1'b0, 40, 4'b0010, 7'd1, 4'b0010, 7'd1);
    tbl[10] = mk(2'b10, 1'b0, 40, 4'b0010, 7'd1, 4'b0100, 7'd2);
    tbl[11] = mk(2'b10, 1'b0, 40, 4'b0010, 7'd1, 4'b0100, 7'd2);
    tbl[12] = mk(2'b11, 1'b0, 40, 4'b0100, 7'd2, 4'b0100, 7'd2);
    tbl[13] = mk(2'b11, 1'b1, 40, 4'b0010, 7'd1, 4'b0010, 7'd1);
`else
    tbl[6]  = mk(2'b01, 1'b0, 40, 4'b1000, 7'd3, 4'b0001, 7'd0);
    tbl[7]  = mk(2'b01, 1'b0, 40, 4'b0001, 7'd4, 4'b0001, 7'd0);
    tbl[8]  = mk(2'b01, 1'b1, 40, 4'b1000, 7'd3, 4'b0001, 7'd0);
    tbl[9]  = mk(2'b10, 1'b0, 40, 4'b1000, 7'd3, 4'b0010, 7'd1);
    tbl[10] = mk(2'b10, 1'b0, 40, 4'b1000, 7'd3, 4'b0100, 7'd2);
    tbl[11] = mk(2'b10, 1'b0, 40, 4'b1000, 7'd3, 4'b1000, 7'd3);
    tbl[12] = mk(2'b11, 1'b0, 40, 4'b0001, 7'd4, 4'b0001, 7'd4);
    tbl[13] = mk(2'b11, 1'b1, 40, 4'b1000, 7'd3, 4'b1000, 7'd3);
`endif

    for (int k = 0; k < 14; k++) begin
      pulse(tbl[k].en, tbl[k].dir, tbl[k].low);
      check_state($sformatf("row%0d", k), tbl[k].c0, tbl[k].t0, tbl[k].c1, tbl[k].t1);
    end

    // Drive select dropped while waiting for the step release: no update.
    en = 2'b01; dir = 1'b0; step = 1'b0;
    repeat (30) @(negedge clk);
    en = 2'b00;
    @(negedge clk);
    step = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    check_state("en_drop", tbl[13].c0, tbl[13].t0, tbl[13].c1, tbl[13].t1);

    // Reset while debouncing restores all reset values on the next edge.
    en = 2'b11; step = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({coils, track, tr0, step_done} !== {8'h11, 14'h0, 2'b11, 2'b00}) begin
      n_fail++;
      $display("FAIL rst_count: got coils=%b track=%h tr0=%b done=%b, expected 00010001/0/11/00",
               coils, track, tr0, step_done);
    end
    rst = 1'b0; step = 1'b1;
    mc[0] = 4'b0001; mc[1] = 4'b0001; mt[0] = '0; mt[1] = '0;
    repeat (DEB + 6) @(negedge clk);
    check_state("post_rst_idle", 4'b0001, 7'd0, 4'b0001, 7'd0);
    pulse(2'b01, 1'b0, 40);
    check_state("post_rst_step", 4'b0010, 7'd1, 4'b0001, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
